// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: packet framer sitting above a UART byte receiver.
// Frames SYNC, LEN, PAYLOAD[LEN], CSUM; buffers the payload; hands each
// checked packet to the host via valid/ready with random-access readout.
// Optional statistics counters are compiled in with UART_RX_PKT_STATS_EN.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 20000,
  localparam int        AW          = $clog2(MAX_LEN),
  localparam int        LW          = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          rx_done,
  input  logic          rx_err,
  input  logic [7:0]    rx_data,
  output logic          rx_en,
`ifdef UART_RX_PKT_STATS_EN
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   err_cnt,
`endif
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          pkt_err,
  output logic [1:0]    err_code
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_PAY, S_CSUM, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          rx_en_q, rx_en_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          pkt_err_q, pkt_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          in_frame;
  logic          len_bad;
  logic          pay_last;
  logic [7:0]    csum_sum;
  logic          err_evt;
  logic [1:0]    err_kind;
  logic          byte_ok;
  logic          good_pkt;
  logic          buf_we;

  // Payload storage; intentionally not reset, only meaningful below pkt_len.
  logic [7:0]    buf_mem [MAX_LEN];

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CSUM);
  assign len_bad  = (rx_data == 8'h00) || ({1'b0, rx_data} > 9'(MAX_LEN));
  assign pay_last = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign csum_sum = csum_q + rx_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; enable-abort beats rx_err, which beats rx_done, which beats timeout
  always_comb begin
    state_d  = state_q;
    err_evt  = 1'b0;
    err_kind = ERR_TIMEOUT;
    byte_ok  = 1'b0;
    good_pkt = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_HDR;
      S_HDR: begin
        if (!enable) state_d = S_IDLE;
        else if (rx_done && !rx_err && (rx_data == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN, S_PAY, S_CSUM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rx_err) begin
          err_evt  = 1'b1;
          err_kind = ERR_FRAME;
          state_d  = S_HDR;
        end else if (rx_done) begin
          byte_ok = 1'b1;
          if (state_q == S_LEN) begin
            if (len_bad) begin
              err_evt  = 1'b1;
              err_kind = ERR_LEN;
              state_d  = S_HDR;
            end else begin
              state_d = S_PAY;
            end
          end else if (state_q == S_PAY) begin
            buf_we = 1'b1;
            if (pay_last) state_d = S_CSUM;
          end else begin
            if (csum_sum == 8'h00) begin
              good_pkt = 1'b1;
              state_d  = S_HOLD;
            end else begin
              err_evt  = 1'b1;
              err_kind = ERR_CSUM;
              state_d  = S_HDR;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          err_evt  = 1'b1;
          err_kind = ERR_TIMEOUT;
          state_d  = S_HDR;
        end
      end
      S_HOLD: begin
        if (pkt_valid_q && pkt_ready) state_d = enable ? S_HDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    rx_en_d     = enable && (state_d inside {S_HDR, S_LEN, S_PAY, S_CSUM});
    pkt_valid_d = (state_d == S_HOLD);
    pkt_err_d   = err_evt;
    err_code_d  = err_evt ? err_kind : err_code_q;
  end

  // Datapath: idle timer, byte index, length, running checksum, held length
  always_comb begin
    tmo_d     = '0;
    idx_d     = idx_q;
    len_d     = len_q;
    csum_d    = csum_q;
    pkt_len_d = pkt_len_q;
    if (in_frame && (state_d == state_q) && !byte_ok) tmo_d = tmo_q + TW'(1);
    if (byte_ok && (state_q == S_LEN) && !len_bad) begin
      len_d  = LW'(rx_data);
      csum_d = rx_data;
      idx_d  = '0;
    end
    if (buf_we) begin
      csum_d = csum_sum;
      if (!pay_last) idx_d = idx_q + AW'(1);
    end
    if (good_pkt) pkt_len_d = len_q;
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      pkt_len_q   <= '0;
      rx_en_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_TIMEOUT;
    end else begin
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      pkt_len_q   <= pkt_len_d;
      rx_en_q     <= rx_en_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload write port
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx_q] <= rx_data;
  end

  assign rd_data   = buf_mem[rd_addr];
  assign rx_en     = rx_en_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;

`ifdef UART_RX_PKT_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating good-packet and error counters
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (good_pkt && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (err_evt  && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl with packet and error scoreboards.
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;
  localparam int AW      = 4;
  localparam int LW      = 5;

  logic          clk = 1'b0;
  logic          rst, enable, rx_done, rx_err, pkt_ready;
  logic [7:0]    rx_data;
  logic [AW-1:0] rd_addr;
  logic          rx_en, pkt_valid, pkt_err;
  logic [LW-1:0] pkt_len;
  logic [7:0]    rd_data;
  logic [1:0]    err_code;
`ifdef UART_RX_PKT_STATS_EN
  logic [15:0]   pkt_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_done(rx_done), .rx_err(rx_err),
    .rx_data(rx_data), .rx_en(rx_en),
`ifdef UART_RX_PKT_STATS_EN
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
`endif
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .pkt_err(pkt_err), .err_code(err_code)
  );

  typedef struct packed {
    logic [7:0]   len;
    logic [127:0] pl;
  } pkt_t;

  pkt_t       exp_pkt_q[$];
  logic [1:0] exp_err_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int n_good   = 0;
  int n_err    = 0;

  // Independent count of every error pulse the DUT emits
  always @(negedge clk) if (rst === 1'b0 && pkt_err === 1'b1) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_err_q.push_back(code);
    n_err++;
  endtask

  task automatic send_good(input logic [7:0] len, input logic [127:0] pl);
    logic [7:0] s;
    pkt_t e;
    s = len;
    e.len = len;
    e.pl  = pl;
    exp_pkt_q.push_back(e);
    n_good++;
    send_byte(8'hA5);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      s = s + pl[i*8 +: 8];
      send_byte(pl[i*8 +: 8]);
    end
    chk("valid_before_csum", 32'(pkt_valid), 32'd0);
    send_byte(8'(8'd0 - s));
    $display("tx packet len=%0d csum=%02h", len, 8'(8'd0 - s));
  endtask

  // Compare the held packet against the scoreboard head
  task automatic check_pkt(input string tag, input bit pop);
    pkt_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_pkt_q.size() > 0), 32'd1);
    if (exp_pkt_q.size() > 0) begin
      e = exp_pkt_q[0];
      if (pop) void'(exp_pkt_q.pop_front());
      chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
      chk({tag, "_len"}, 32'(pkt_len), 32'(e.len));
      for (int i = 0; i < int'(e.len); i++) begin
        @(negedge clk);
        rd_addr = AW'(i);
        #1;
        chk({tag, "_data"}, 32'(rd_data), 32'(e.pl[i*8 +: 8]));
      end
      $display("rx packet %s len=%0d", tag, pkt_len);
    end
  endtask

  task automatic accept(input string tag);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_rx_en"}, 32'(rx_en), 32'(enable));
  endtask

  // Error is expected on the cycle just completed, lasting one cycle
  task automatic expect_err(input string tag);
    logic [1:0] c;
    c = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 2'bxx;
    chk({tag, "_pulse"}, 32'(pkt_err), 32'd1);
    chk({tag, "_code"}, 32'(err_code), 32'(c));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(pkt_err), 32'd0);
    chk({tag, "_code_hold"}, 32'(err_code), 32'(c));
    chk({tag, "_no_valid"}, 32'(pkt_valid), 32'd0);
    $display("error %s code=%0b", tag, err_code);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx_done = 1'b0; rx_err = 1'b0;
    rx_data = 8'h00; pkt_ready = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_len", 32'(pkt_len), 32'd0);
    chk("rst_err", 32'(pkt_err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_en", 32'(rx_en), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("hdr_rx_en", 32'(rx_en), 32'd1);

    // Good packet A5 03 11 22 33 97
    send_good(8'd3, 128'h332211);
    check_pkt("good1", 1'b1);
    accept("good1");

    // Checksum error, then a one-byte packet
    push_err(2'b11);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    expect_err("csum");
    send_good(8'd1, 128'hFF);
    check_pkt("good2", 1'b1);
    accept("good2");

    // Stray byte then bad lengths
    send_byte(8'h3C);
    chk("stray_no_err", 32'(pkt_err), 32'd0);
    push_err(2'b10);
    send_byte(8'hA5); send_byte(8'h00);
    expect_err("len0");
    push_err(2'b10);
    send_byte(8'hA5); send_byte(8'h11);
    expect_err("len17");

    // Framing error mid-payload, then rx_err together with rx_done
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    push_err(2'b01);
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    expect_err("frame");
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    push_err(2'b01);
    @(negedge clk); rx_err = 1'b1; rx_done = 1'b1; rx_data = 8'h77;
    @(negedge clk); rx_err = 1'b0; rx_done = 1'b0;
    expect_err("frame_dup");
    send_good(8'd2, 128'hBEEF);
    check_pkt("good3", 1'b1);
    accept("good3");

    // Timeout: pulse exactly 51 edges after the last accepted byte
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
    push_err(2'b00);
    repeat (TMO) begin
      @(negedge clk);
      chk("tmo_quiet", 32'(pkt_err), 32'd0);
    end
    @(negedge clk);
    expect_err("timeout");

    // Byte landing on the firing cycle suppresses the timeout
    begin
      pkt_t e;
      e.len = 8'd4;
      e.pl  = 128'h44332211;
      exp_pkt_q.push_back(e);
      n_good++;
    end
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
    repeat (TMO) @(negedge clk);
    rx_done = 1'b1; rx_data = 8'h22;
    @(negedge clk);
    rx_done = 1'b0;
    chk("tmo_suppressed", 32'(pkt_err), 32'd0);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h52);
    check_pkt("tmo_edge", 1'b1);
    accept("tmo_edge");

    // Full-length packet held under backpressure with bytes still arriving
    send_good(8'd16, {$urandom(), $urandom(), $urandom(), $urandom()});
    check_pkt("full", 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      rx_done = c[0];
      rx_data = (c % 5 == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      if (c == 50) enable = 1'b0;
      #1;
      chk("hold_rx_en", 32'(rx_en), 32'd0);
      chk("hold_valid", 32'(pkt_valid), 32'd1);
    end
    @(negedge clk);
    rx_done = 1'b0;
    check_pkt("full_after_hold", 1'b1);
    accept("full");
    @(negedge clk);
    chk("idle_after_hold", 32'(rx_en), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_rx_en", 32'(rx_en), 32'd1);

    // Abort mid-payload
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk); enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_rx_en", 32'(rx_en), 32'd0);
      chk("abort_no_err", 32'(pkt_err), 32'd0);
    end
    chk("abort_no_valid", 32'(pkt_valid), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("abort_reenable", 32'(rx_en), 32'd1);
    send_good(8'd2, 128'h5AC3);
    check_pkt("good4", 1'b1);
    accept("good4");

    repeat (3) @(negedge clk);
    chk("err_total", 32'(err_seen), 32'(n_err));
    chk("err_sb_empty", 32'(exp_err_q.size()), 32'd0);
    chk("pkt_sb_empty", 32'(exp_pkt_q.size()), 32'd0);
`ifdef UART_RX_PKT_STATS_EN
    chk("stat_pkt_cnt", 32'(pkt_cnt), 32'(n_good));
    chk("stat_err_cnt", 32'(err_cnt), 32'(n_err));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
